// File: rtl/remote_cmd_tx.sv
// remote_cmd_tx: frames an 8-bit opcode and 16-bit payload into three UART
// bytes (cmd, data[15:8], data[7:0]), then waits for a one-byte response
// from the airframe command handler or gives up after TIMEOUT_CYC cycles.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   snd_cmd      request to send {cmd,data}; only honoured in IDLE
//   cmd, data    opcode and payload, shadowed on acceptance
//   tx_done      UART transmitter finished the current byte (pulse)
//   rx_rdy       UART receiver holds a byte (level until cleared)
//   rx_data      received byte
//   trmt         start UART transmit of tx_data (pulse)
//   tx_data      byte to transmit, held until the next trmt
//   clr_rx_rdy   knock down UART rx_rdy (pulse)
//   busy         high in every state except IDLE
//   cmd_sent     last frame byte finished transmitting (pulse)
//   resp_rdy     response byte captured into resp (pulse)
//   resp         last captured response byte
//   ack_ok       resp equals ACK_BYTE
//   timeout      no response within TIMEOUT_CYC cycles (pulse)
module remote_cmd_tx #(
    parameter int unsigned TIMEOUT_CYC = 2**20,
    parameter logic [7:0]  ACK_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        tx_done,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        clr_rx_rdy,
    output logic        busy,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    output logic        ack_ok,
    output logic        timeout
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_CMD,
        S_TX_HI,
        S_TX_LO,
        S_WAIT_RESP
    } state_t;

    state_t        r_state;
    logic [7:0]    r_cmd;
    logic [15:0]   r_data;
    logic [TW-1:0] r_timer;
    logic          r_trmt;
    logic [7:0]    r_tx_data;
    logic          r_clr_rx_rdy;
    logic          r_busy;
    logic          r_cmd_sent;
    logic          r_resp_rdy;
    logic [7:0]    r_resp;
    logic          r_ack_ok;
    logic          r_timeout;

    // rx_rdy stays high for one edge after our clear pulse; don't treat
    // that lingering level as a new byte.
    logic w_rx_new;
    assign w_rx_new = rx_rdy && !r_clr_rx_rdy;

    // Frame/response sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cmd        <= 8'h00;
            r_data       <= 16'h0000;
            r_timer      <= '0;
            r_trmt       <= 1'b0;
            r_tx_data    <= 8'h00;
            r_clr_rx_rdy <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd_sent   <= 1'b0;
            r_resp_rdy   <= 1'b0;
            r_resp       <= 8'h00;
            r_ack_ok     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_trmt       <= 1'b0;
            r_cmd_sent   <= 1'b0;
            r_resp_rdy   <= 1'b0;
            r_timeout    <= 1'b0;
            r_clr_rx_rdy <= 1'b0;

            // Stale byte outside WAIT_RESP: discard it without touching resp.
            if (w_rx_new && (r_state != S_WAIT_RESP)) begin
                r_clr_rx_rdy <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (snd_cmd) begin
                        r_cmd     <= cmd;
                        r_data    <= data;
                        r_tx_data <= cmd;
                        r_trmt    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_TX_CMD;
                    end
                end
                S_TX_CMD: begin
                    if (tx_done) begin
                        r_tx_data <= r_data[15:8];
                        r_trmt    <= 1'b1;
                        r_state   <= S_TX_HI;
                    end
                end
                S_TX_HI: begin
                    if (tx_done) begin
                        r_tx_data <= r_data[7:0];
                        r_trmt    <= 1'b1;
                        r_state   <= S_TX_LO;
                    end
                end
                S_TX_LO: begin
                    if (tx_done) begin
                        r_cmd_sent <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    // A response on the expiry cycle still counts.
                    if (w_rx_new) begin
                        r_resp       <= rx_data;
                        r_ack_ok     <= (rx_data == ACK_BYTE);
                        r_resp_rdy   <= 1'b1;
                        r_clr_rx_rdy <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (r_timer == TMAX) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign trmt       = r_trmt;
    assign tx_data    = r_tx_data;
    assign clr_rx_rdy = r_clr_rx_rdy;
    assign busy       = r_busy;
    assign cmd_sent   = r_cmd_sent;
    assign resp_rdy   = r_resp_rdy;
    assign resp       = r_resp;
    assign ack_ok     = r_ack_ok;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Testbench for remote_cmd_tx: table of command/response transactions plus
// directed sequences for timeout, response-on-expiry, snd_cmd during a frame,
// reset mid-frame and stale receive bytes.
module tb_remote_cmd_tx;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        tx_done;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        clr_rx_rdy;
    logic        busy;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        ack_ok;
    logic        timeout;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [7:0]  rx_byte;
        logic        exp_ack;
    } vec_t;

    vec_t vecs[5];

    remote_cmd_tx #(.TIMEOUT_CYC(TO), .ACK_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .snd_cmd    (snd_cmd),
        .cmd        (cmd),
        .data       (data),
        .tx_done    (tx_done),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .busy       (busy),
        .cmd_sent   (cmd_sent),
        .resp_rdy   (resp_rdy),
        .resp       (resp),
        .ack_ok     (ack_ok),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one frame; the UART model answers each trmt with tx_done 4 cycles later.
    task automatic send_frame(input logic [7:0] c, input logic [15:0] d, input bit disturb);
        logic [7:0] exp_b [3];
        int bad;
        exp_b[0] = c;
        exp_b[1] = d[15:8];
        exp_b[2] = d[7:0];
        snd_cmd = 1'b1; cmd = c; data = d;
        step();
        snd_cmd = 1'b0;
        for (int b = 0; b < 3; b++) begin
            chk("trmt_on",  32'(trmt), 32'd1);
            chk("tx_data",  32'(tx_data), 32'(exp_b[b]));
            chk("busy_tx",  32'(busy), 32'd1);
            bad = 0;
            for (int k = 0; k < 3; k++) begin
                if (disturb && b == 1 && k == 0) begin
                    snd_cmd = 1'b1; cmd = 8'h08; data = 16'hFFFF;
                end
                step();
                if (disturb && b == 1 && k == 0) snd_cmd = 1'b0;
                if (trmt !== 1'b0 || tx_data !== exp_b[b] || cmd_sent !== 1'b0) bad++;
            end
            chk("trmt_single_hold", 32'(bad), 32'd0);
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
        end
        chk("cmd_sent",   32'(cmd_sent), 32'd1);
        chk("trmt_after", 32'(trmt), 32'd0);
        chk("busy_wait",  32'(busy), 32'd1);
    endtask

    // Deliver a response byte; UART clears rx_rdy on the edge after clr_rx_rdy.
    task automatic respond(input logic [7:0] rb, input logic exp_ack);
        rx_rdy = 1'b1; rx_data = rb;
        step();
        chk("resp_rdy",     32'(resp_rdy), 32'd1);
        chk("clr_rx_rdy",   32'(clr_rx_rdy), 32'd1);
        chk("resp",         32'(resp), 32'(rb));
        chk("ack_ok",       32'(ack_ok), 32'(exp_ack));
        chk("busy_done",    32'(busy), 32'd0);
        chk("no_timeout",   32'(timeout), 32'd0);
        chk("cmd_sent_once", 32'(cmd_sent), 32'd0);
        step();
        rx_rdy = 1'b0;
        chk("resp_rdy_pulse", 32'(resp_rdy), 32'd0);
        chk("clr_pulse",      32'(clr_rx_rdy), 32'd0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{cmd: 8'h05, data: 16'h01C0, rx_byte: 8'hA5, exp_ack: 1'b1};
        vecs[1] = '{cmd: 8'h02, data: 16'h1234, rx_byte: 8'h5A, exp_ack: 1'b0};
        vecs[2] = '{cmd: 8'h03, data: 16'h0000, rx_byte: 8'h00, exp_ack: 1'b0};
        vecs[3] = '{cmd: 8'h06, data: 16'h8001, rx_byte: 8'hA4, exp_ack: 1'b0};
        vecs[4] = '{cmd: 8'h07, data: 16'hFFFF, rx_byte: 8'hA5, exp_ack: 1'b1};

        rst_n = 1'b0; snd_cmd = 1'b0; cmd = 8'h00; data = 16'h0000;
        tx_done = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
        #12;
        chk("rst_trmt",    32'(trmt), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_resp",    32'(resp), 32'd0);
        chk("rst_ack",     32'(ack_ok), 32'd0);
        chk("rst_pulses",  32'({clr_rx_rdy, cmd_sent, resp_rdy, timeout}), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Table of full transactions, back to back.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].cmd, vecs[i].data, 1'b0);
            respond(vecs[i].rx_byte, vecs[i].exp_ack);
        end

        // No response: timeout 16 cycles after WAIT_RESP entry, resp kept (A5, ack 1).
        send_frame(8'h04, 16'h0102, 1'b0);
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            step();
            if (timeout !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk("no_early_timeout", 32'(bad), 32'd0);
        step();
        chk("timeout",        32'(timeout), 32'd1);
        chk("timeout_busy",   32'(busy), 32'd0);
        chk("timeout_resp",   32'(resp), 32'hA5);
        chk("timeout_ack",    32'(ack_ok), 32'd1);
        chk("timeout_nordy",  32'(resp_rdy), 32'd0);
        step();
        chk("timeout_pulse",  32'(timeout), 32'd0);

        // Response arrives on the exact expiry edge: response wins.
        send_frame(8'h02, 16'h00FF, 1'b0);
        repeat (15) step();
        rx_rdy = 1'b1; rx_data = 8'h5A;
        step();
        chk("expiry_resp_rdy", 32'(resp_rdy), 32'd1);
        chk("expiry_timeout",  32'(timeout), 32'd0);
        chk("expiry_resp",     32'(resp), 32'h5A);
        chk("expiry_ack",      32'(ack_ok), 32'd0);
        chk("expiry_busy",     32'(busy), 32'd0);
        step();
        rx_rdy = 1'b0;
        chk("expiry_late_timeout", 32'(timeout), 32'd0);

        // snd_cmd with new cmd/data during TX_HI must not disturb the frame.
        send_frame(8'h03, 16'hBEEF, 1'b1);
        respond(8'hA5, 1'b1);

        // Reset in TX_HI aborts the frame immediately.
        snd_cmd = 1'b1; cmd = 8'h06; data = 16'h1357;
        step();
        snd_cmd = 1'b0;
        chk("r6_trmt0", 32'(trmt), 32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("r6_tx_hi", 32'(tx_data), 32'h13);
        #2 rst_n = 1'b0;
        #1;
        chk("r6_trmt",    32'(trmt), 32'd0);
        chk("r6_busy",    32'(busy), 32'd0);
        chk("r6_tx_data", 32'(tx_data), 32'd0);
        chk("r6_resp",    32'(resp), 32'd0);
        chk("r6_ack",     32'(ack_ok), 32'd0);
        step();
        rst_n = 1'b1;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("r6_no_resume", 32'({trmt, busy}), 32'd0);

        // Stale byte in IDLE: only clr_rx_rdy reacts.
        rx_rdy = 1'b1; rx_data = 8'hA5;
        step();
        chk("stale_clr",  32'(clr_rx_rdy), 32'd1);
        chk("stale_rdy",  32'(resp_rdy), 32'd0);
        chk("stale_resp", 32'(resp), 32'd0);
        chk("stale_ack",  32'(ack_ok), 32'd0);
        chk("stale_busy", 32'(busy), 32'd0);
        step();
        rx_rdy = 1'b0;
        chk("stale_clr_pulse", 32'(clr_rx_rdy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
